// File: rtl/sp_ram_arbiter.sv
// Two-master round-robin front-end for a single-port synchronous RAM.
// Decodes the RAM window, steers read data back to the granted master, flags out-of-window accesses.
module sp_ram_arbiter #(
  parameter int unsigned RAM_SIZE   = 32768,
  parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0010_0000
) (
  input  logic                  clk,
  input  logic                  rstn_i,

  input  logic                  m0_req_i,
  output logic                  m0_gnt_o,
  input  logic [31:0]           m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_be_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  output logic                  m0_err_o,

  input  logic                  m1_req_i,
  output logic                  m1_gnt_o,
  input  logic [31:0]           m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_be_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  m1_err_o,

  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  // Handshake: a master's request is accepted in the cycle where req and gnt are both high;
  // the address phase completes there. Exactly one rvalid follows on the next cycle, with no
  // backpressure. rdata/err are meaningful only while rvalid is high. A master may hold req
  // after a grant, which is simply a fresh request in the following cycle.

  logic                  prio_q, prio_d;
  logic                  both_req;
  logic                  gnt0, gnt1, any_gnt;

  logic [31:0]           sel_addr;
  logic                  sel_we;
  logic [3:0]            sel_be;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  in_win;
  logic                  ram_en;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_id_q, rsp_id_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_rd_q, rsp_rd_d;
  logic [DATA_WIDTH-1:0] rsp_data;

  // prio_q names the master that wins the next conflict; only conflicts rotate it.
  assign both_req = m0_req_i & m1_req_i;
  assign gnt0     = m0_req_i & (~m1_req_i | ~prio_q);
  assign gnt1     = m1_req_i & (~m0_req_i | prio_q);
  assign any_gnt  = gnt0 | gnt1;
  assign prio_d   = both_req ? ~prio_q : prio_q;

  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;

  always_comb begin
    sel_addr  = m0_addr_i;
    sel_we    = m0_we_i;
    sel_be    = m0_be_i;
    sel_wdata = m0_wdata_i;
    if (gnt1) begin
      sel_addr  = m1_addr_i;
      sel_we    = m1_we_i;
      sel_be    = m1_be_i;
      sel_wdata = m1_wdata_i;
    end
  end

  assign in_win = (sel_addr[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
  assign ram_en = any_gnt & in_win;

  // Address/data lines keep their last driven value while the RAM is idle to avoid toggling.
  always_comb begin
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    if (ram_en) begin
      addr_d  = sel_addr[ADDR_WIDTH-1:0];
      be_d    = sel_be;
      wdata_d = sel_wdata;
    end
  end

  assign ram_en_o    = ram_en;
  assign ram_we_o    = ram_en & sel_we;
  assign ram_addr_o  = addr_d;
  assign ram_be_o    = be_d;
  assign ram_wdata_o = wdata_d;

  always_comb begin
    rsp_valid_d = any_gnt;
    rsp_id_d    = gnt1;
    rsp_err_d   = any_gnt & ~in_win;
    rsp_rd_d    = any_gnt & in_win & ~sel_we;
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      prio_q      <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rd_q    <= 1'b0;
    end else begin
      prio_q      <= prio_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rd_q    <= rsp_rd_d;
    end
  end

  // RAM read data is muxed straight through so the response adds no cycle beyond the RAM's own.
  assign rsp_data    = (rsp_valid_q & rsp_rd_q) ? ram_rdata_i : '0;

  assign m0_rvalid_o = rsp_valid_q & ~rsp_id_q;
  assign m1_rvalid_o = rsp_valid_q & rsp_id_q;
  assign m0_err_o    = m0_rvalid_o & rsp_err_q;
  assign m1_err_o    = m1_rvalid_o & rsp_err_q;
  assign m0_rdata_o  = rsp_id_q ? '0 : rsp_data;
  assign m1_rdata_o  = rsp_id_q ? rsp_data : '0;

endmodule
